rp_adc_dac_cal: RTL and testbench

Parametrised multi-channel fast-ADC/DAC data-path stage sitting between the raw converter pins and user logic in the `adc_clk` domain. Converts raw offset-binary ADC codes of either slope polarity to 2's complement, and 2's-complement DAC data back to raw codes. Each channel path applies atomically loaded offset/gain calibration with rounding and saturation, and latches sticky overrange flags. The DAC side adds ramp test-pattern and ADC-to-DAC loopback modes.

---
 rtl/rp_adc_dac_pkg.sv | 35 +++
 rtl/rp_cal_lane.sv | 85 ++++++++
 rtl/rp_adc_dac_cal.sv | 175 +++++++++++++++++
 tb/tb_rp_adc_dac_cal.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rp_adc_dac_pkg.sv
// Shared mode encoding, raw/2's-complement code mapping and gain constants
// for the fast ADC/DAC calibration data path.
package rp_adc_dac_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_MUTE   = 2'd2,
        MODE_LOOP   = 2'd3
    } dac_mode_e;

    // Bits flipped by the raw <-> 2's mapping: all but the MSB for a
    // negative-slope converter, only the MSB for a positive-slope one.
    function automatic logic [31:0] conv_mask(input int w, input bit inv);
        return inv ? ((32'd1 << (w - 1)) - 32'd1) : (32'd1 << (w - 1));
    endfunction

    function automatic logic [31:0] raw2twos(input logic [31:0] b, input int w, input bit inv);
        return b ^ conv_mask(w, inv);
    endfunction

    // The mapping is an involution, so the reverse direction is the same XOR.
    function automatic logic [31:0] twos2raw(input logic [31:0] b, input int w, input bit inv);
        return raw2twos(b, w, inv);
    endfunction

    function automatic logic [31:0] gain_unity(input int gw);
        return 32'd1 << (gw - 2);
    endfunction

    function automatic logic [31:0] gain_round(input int gw);
        return 32'd1 << (gw - 3);
    endfunction

endpackage

// File: rtl/rp_cal_lane.sv
// One calibration lane: register, add offset, multiply by gain, then round,
// shift back to sample scale and saturate. A bypass bit travels with the
// sample and forces a clean zero out (used for DAC mute).
module rp_cal_lane
    import rp_adc_dac_pkg::*;
#(
    parameter int W      = 14,
    parameter int GAIN_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_byp,
    input  logic signed [W-1:0]      i_x,
    input  logic signed [W-1:0]      i_off,
    input  logic signed [GAIN_W-1:0] i_gain,
    output logic signed [W-1:0]      o_y,
    output logic                     o_sat
);

    localparam int P  = W + GAIN_W + 1;
    localparam int SW = P + 1;
    localparam logic signed [SW-1:0] C_RND = SW'(gain_round(GAIN_W));
    localparam logic signed [SW-1:0] C_MAX = (SW'(1) <<< (W - 1)) - SW'(1);
    localparam logic signed [SW-1:0] C_MIN = -(SW'(1) <<< (W - 1));

    logic signed [W-1:0]      r_x1;
    logic                     r_b1;
    logic signed [W:0]        r_s2;
    logic signed [GAIN_W-1:0] r_g2;
    logic                     r_b2;
    logic signed [P-1:0]      r_s3;
    logic                     r_b3;
    logic signed [W-1:0]      r_y;
    logic                     r_sat;

    logic signed [P-1:0]      w_prod;
    logic signed [SW-1:0]     w_sum;
    logic signed [SW-1:0]     w_shr;

    // Gain travels with its sample from S2 so a shadow reload never mixes
    // an old offset with a new gain on the same sample.
    assign w_prod = $signed({{GAIN_W{r_s2[W]}}, r_s2}) * $signed({{(W + 1){r_g2[GAIN_W-1]}}, r_g2});
    assign w_sum  = $signed({r_s3[P-1], r_s3}) + C_RND;
    assign w_shr  = w_sum >>> (GAIN_W - 2);

    // S1..S4 pipeline with saturation pulse aligned to the S4 output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x1  <= '0;
            r_b1  <= 1'b0;
            r_s2  <= '0;
            r_g2  <= '0;
            r_b2  <= 1'b0;
            r_s3  <= '0;
            r_b3  <= 1'b0;
            r_y   <= '0;
            r_sat <= 1'b0;
        end else begin
            r_x1 <= i_x;
            r_b1 <= i_byp;
            r_s2 <= {r_x1[W-1], r_x1} + {i_off[W-1], i_off};
            r_g2 <= i_gain;
            r_b2 <= r_b1;
            r_s3 <= w_prod;
            r_b3 <= r_b2;
            if (r_b3) begin
                r_y   <= '0;
                r_sat <= 1'b0;
            end else if (w_shr > C_MAX) begin
                r_y   <= W'(C_MAX);
                r_sat <= 1'b1;
            end else if (w_shr < C_MIN) begin
                r_y   <= W'(C_MIN);
                r_sat <= 1'b1;
            end else begin
                r_y   <= w_shr[W-1:0];
                r_sat <= 1'b0;
            end
        end
    end

    assign o_y   = r_y;
    assign o_sat = r_sat;

endmodule

// File: rtl/rp_adc_dac_cal.sv
// Multi-channel ADC/DAC data-path stage: raw code conversion, shadowed
// offset/gain calibration, sticky overrange/saturation flags, and DAC
// ramp / mute / loopback sources.
module rp_adc_dac_cal
    import rp_adc_dac_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int ADC_DW  = 14,
    parameter int DAC_DW  = 14,
    parameter int GAIN_W  = 16,
    parameter bit ADC_INV = 1'b1,
    parameter bit DAC_INV = 1'b1
) (
    input  logic                     adc_clk,
    input  logic                     adc_rst_i,
    input  logic [N_CH*ADC_DW-1:0]   adc_dat_raw_i,
    output logic [N_CH*ADC_DW-1:0]   adc_dat_o,
    output logic                     adc_valid_o,
    output logic [N_CH-1:0]          adc_ovr_o,
    input  logic [N_CH*DAC_DW-1:0]   dac_dat_i,
    output logic [N_CH*DAC_DW-1:0]   dac_dat_raw_o,
    output logic [N_CH-1:0]          dac_sat_o,
    input  logic [1:0]               dac_mode_i,
    input  logic [N_CH*ADC_DW-1:0]   adc_off_i,
    input  logic [N_CH*DAC_DW-1:0]   dac_off_i,
    input  logic [N_CH*GAIN_W-1:0]   adc_gain_i,
    input  logic [N_CH*GAIN_W-1:0]   dac_gain_i,
    input  logic                     cfg_load_i,
    input  logic                     ovr_clr_i
);

    localparam logic [GAIN_W-1:0] C_UNITY   = GAIN_W'(gain_unity(GAIN_W));
    localparam logic [DAC_DW-1:0] C_DAC_MID = DAC_DW'(twos2raw(32'd0, DAC_DW, DAC_INV));

    logic [N_CH*ADC_DW-1:0] r_adc_off;
    logic [N_CH*DAC_DW-1:0] r_dac_off;
    logic [N_CH*GAIN_W-1:0] r_adc_gain;
    logic [N_CH*GAIN_W-1:0] r_dac_gain;
    logic [DAC_DW-1:0]      r_ramp;
    logic [3:0]             r_vld;
    dac_mode_e              w_mode;

    assign w_mode = dac_mode_e'(dac_mode_i);

    // Shadow calibration: every channel switches on the same strobe
    always_ff @(posedge adc_clk or negedge adc_rst_i) begin
        if (!adc_rst_i) begin
            r_adc_off  <= '0;
            r_dac_off  <= '0;
            r_adc_gain <= {N_CH{C_UNITY}};
            r_dac_gain <= {N_CH{C_UNITY}};
        end else if (cfg_load_i) begin
            r_adc_off  <= adc_off_i;
            r_dac_off  <= dac_off_i;
            r_adc_gain <= adc_gain_i;
            r_dac_gain <= dac_gain_i;
        end
    end

    // Shared ramp: held at 0 outside ramp mode so every entry starts at 0
    always_ff @(posedge adc_clk or negedge adc_rst_i) begin
        if (!adc_rst_i) begin
            r_ramp <= '0;
        end else if (w_mode == MODE_RAMP) begin
            r_ramp <= r_ramp + DAC_DW'(1);
        end else begin
            r_ramp <= '0;
        end
    end

    // Valid follows the ADC pipeline fill after reset release
    always_ff @(posedge adc_clk or negedge adc_rst_i) begin
        if (!adc_rst_i) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[2:0], 1'b1};
        end
    end

    assign adc_valid_o = r_vld[3];

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [ADC_DW-1:0]        w_adc_raw;
        logic signed [ADC_DW-1:0] w_adc_x;
        logic signed [ADC_DW-1:0] w_adc_y;
        logic                     w_adc_ext;
        logic                     w_adc_sat;
        logic                     r_adc_ovr;
        logic signed [DAC_DW-1:0] w_loop;
        logic signed [DAC_DW-1:0] w_dac_src;
        logic signed [DAC_DW-1:0] w_dac_y;
        logic                     w_dac_byp;
        logic                     w_dac_sat;
        logic                     r_dac_sat;
        logic [DAC_DW-1:0]        r_dac_raw;

        assign w_adc_raw = adc_dat_raw_i[ch*ADC_DW +: ADC_DW];
        assign w_adc_x   = ADC_DW'(raw2twos(32'(w_adc_raw), ADC_DW, ADC_INV));
        assign w_adc_ext = (&w_adc_raw) | ~(|w_adc_raw);

        rp_cal_lane #(.W(ADC_DW), .GAIN_W(GAIN_W)) u_adc_lane (
            .clk    (adc_clk),
            .rst_n  (adc_rst_i),
            .i_byp  (1'b0),
            .i_x    (w_adc_x),
            .i_off  (r_adc_off[ch*ADC_DW +: ADC_DW]),
            .i_gain (r_adc_gain[ch*GAIN_W +: GAIN_W]),
            .o_y    (w_adc_y),
            .o_sat  (w_adc_sat)
        );

        assign adc_dat_o[ch*ADC_DW +: ADC_DW] = w_adc_y;

        // Sticky ADC overrange; a new event beats a simultaneous clear
        always_ff @(posedge adc_clk or negedge adc_rst_i) begin
            if (!adc_rst_i) begin
                r_adc_ovr <= 1'b0;
            end else begin
                r_adc_ovr <= w_adc_ext | w_adc_sat | (r_adc_ovr & ~ovr_clr_i);
            end
        end

        assign adc_ovr_o[ch] = r_adc_ovr;

        // Loopback is MSB-aligned so full scale maps to full scale
        if (DAC_DW == ADC_DW) begin : g_loop_eq
            assign w_loop = w_adc_y;
        end else if (DAC_DW > ADC_DW) begin : g_loop_pad
            assign w_loop = {w_adc_y, {(DAC_DW - ADC_DW){1'b0}}};
        end else begin : g_loop_trunc
            assign w_loop = w_adc_y[ADC_DW-1 -: DAC_DW];
        end

        // DAC source select at the lane input
        always_comb begin
            w_dac_src = dac_dat_i[ch*DAC_DW +: DAC_DW];
            w_dac_byp = 1'b0;
            case (w_mode)
                MODE_RAMP: w_dac_src = r_ramp;
                MODE_MUTE: begin
                    w_dac_src = '0;
                    w_dac_byp = 1'b1;
                end
                MODE_LOOP: w_dac_src = w_loop;
                default:   ;
            endcase
        end

        rp_cal_lane #(.W(DAC_DW), .GAIN_W(GAIN_W)) u_dac_lane (
            .clk    (adc_clk),
            .rst_n  (adc_rst_i),
            .i_byp  (w_dac_byp),
            .i_x    (w_dac_src),
            .i_off  (r_dac_off[ch*DAC_DW +: DAC_DW]),
            .i_gain (r_dac_gain[ch*GAIN_W +: GAIN_W]),
            .o_y    (w_dac_y),
            .o_sat  (w_dac_sat)
        );

        // Registered raw DAC code and sticky saturation flag
        always_ff @(posedge adc_clk or negedge adc_rst_i) begin
            if (!adc_rst_i) begin
                r_dac_raw <= C_DAC_MID;
                r_dac_sat <= 1'b0;
            end else begin
                r_dac_raw <= DAC_DW'(twos2raw(32'(w_dac_y), DAC_DW, DAC_INV));
                r_dac_sat <= w_dac_sat | (r_dac_sat & ~ovr_clr_i);
            end
        end

        assign dac_dat_raw_o[ch*DAC_DW +: DAC_DW] = r_dac_raw;
        assign dac_sat_o[ch] = r_dac_sat;
    end

endmodule

// File: tb/tb_rp_adc_dac_cal.sv
// Directed-vector bench for rp_adc_dac_cal with default parameters
// (2 channels, 14-bit, 16-bit gain, negative-slope coding both sides).
module tb_rp_adc_dac_cal;

    localparam int N_CH   = 2;
    localparam int ADC_DW = 14;
    localparam int DAC_DW = 14;
    localparam int GAIN_W = 16;

    logic                   adc_clk = 1'b0;
    logic                   adc_rst_i = 1'b0;
    logic [N_CH*ADC_DW-1:0] adc_dat_raw_i;
    logic [N_CH*ADC_DW-1:0] adc_dat_o;
    logic                   adc_valid_o;
    logic [N_CH-1:0]        adc_ovr_o;
    logic [N_CH*DAC_DW-1:0] dac_dat_i;
    logic [N_CH*DAC_DW-1:0] dac_dat_raw_o;
    logic [N_CH-1:0]        dac_sat_o;
    logic [1:0]             dac_mode_i;
    logic [N_CH*ADC_DW-1:0] adc_off_i;
    logic [N_CH*DAC_DW-1:0] dac_off_i;
    logic [N_CH*GAIN_W-1:0] adc_gain_i;
    logic [N_CH*GAIN_W-1:0] dac_gain_i;
    logic                   cfg_load_i;
    logic                   ovr_clr_i;

    int n_vec = 0;
    int n_err = 0;

    rp_adc_dac_cal dut (
        .adc_clk       (adc_clk),
        .adc_rst_i     (adc_rst_i),
        .adc_dat_raw_i (adc_dat_raw_i),
        .adc_dat_o     (adc_dat_o),
        .adc_valid_o   (adc_valid_o),
        .adc_ovr_o     (adc_ovr_o),
        .dac_dat_i     (dac_dat_i),
        .dac_dat_raw_o (dac_dat_raw_o),
        .dac_sat_o     (dac_sat_o),
        .dac_mode_i    (dac_mode_i),
        .adc_off_i     (adc_off_i),
        .dac_off_i     (dac_off_i),
        .adc_gain_i    (adc_gain_i),
        .dac_gain_i    (dac_gain_i),
        .cfg_load_i    (cfg_load_i),
        .ovr_clr_i     (ovr_clr_i)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int adc_val(input int ch);
        return int'($signed(adc_dat_o[ch*ADC_DW +: ADC_DW]));
    endfunction

    function automatic int dac_raw(input int ch);
        return int'(dac_dat_raw_o[ch*DAC_DW +: DAC_DW]);
    endfunction

    // Stimulus only: negative-slope raw code for a 2's-complement value
    function automatic logic [13:0] adc_raw_of(input int v);
        logic [13:0] t;
        t = 14'(v);
        return t ^ 14'h1FFF;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge adc_clk);
        #1;
    endtask

    task automatic set_adc(input int v0, input int v1);
        adc_dat_raw_i = {adc_raw_of(v1), adc_raw_of(v0)};
    endtask

    task automatic set_dac(input int v0, input int v1);
        dac_dat_i = {14'(v1), 14'(v0)};
    endtask

    task automatic stage_cal(input int a_off, input int a_gain, input int d_off, input int d_gain);
        adc_off_i  = {2{14'(a_off)}};
        adc_gain_i = {2{16'(a_gain)}};
        dac_off_i  = {2{14'(d_off)}};
        dac_gain_i = {2{16'(d_gain)}};
    endtask

    task automatic pulse_load();
        cfg_load_i = 1'b1;
        step(1);
        cfg_load_i = 1'b0;
    endtask

    task automatic pulse_clr();
        ovr_clr_i = 1'b1;
        step(1);
        ovr_clr_i = 1'b0;
    endtask

    initial begin
        adc_dat_raw_i = '0;
        dac_dat_i     = '0;
        dac_mode_i    = 2'd0;
        cfg_load_i    = 1'b0;
        ovr_clr_i     = 1'b0;
        stage_cal(0, 16384, 0, 16384);

        // reset defaults
        step(3);
        check_val("rst_dac_raw0", dac_raw(0), 'h1FFF);
        check_val("rst_dac_raw1", dac_raw(1), 'h1FFF);
        check_val("rst_adc_dat", adc_val(0), 0);
        check_val("rst_valid", int'(adc_valid_o), 0);
        check_val("rst_ovr", int'(adc_ovr_o), 0);
        adc_rst_i = 1'b1;
        step(3);
        check_val("valid_n3", int'(adc_valid_o), 0);
        check_val("adc_n3", adc_val(0), 0);
        step(1);
        check_val("valid_n4", int'(adc_valid_o), 1);
        check_val("adc_raw0_ch0", adc_val(0), 8191);
        check_val("adc_raw0_ch1", adc_val(1), 8191);
        check_val("ovr_extreme", int'(adc_ovr_o), 3);
        check_val("dac_idle", dac_raw(0), 'h1FFF);

        // staged gain without strobe has no effect
        set_adc(1000, -2000);
        stage_cal(0, 24576, 0, 16384);
        step(3);
        check_val("adc_lat_n3", adc_val(0), 8191);
        step(1);
        check_val("nostrobe_ch0", adc_val(0), 1000);
        check_val("nostrobe_ch1", adc_val(1), -2000);
        step(2);
        pulse_load();
        step(2);
        check_val("load_old_sample", adc_val(0), 1000);
        step(1);
        check_val("gain15_ch0", adc_val(0), 1500);
        check_val("gain15_ch1", adc_val(1), -3000);

        // sticky clear without a new event
        pulse_clr();
        check_val("ovr_cleared", int'(adc_ovr_o), 0);

        // positive saturation from gain
        stage_cal(0, 32767, 0, 16384);
        set_adc(8000, 1000);
        pulse_load();
        step(4);
        check_val("sat_hi_ch0", adc_val(0), 8191);
        check_val("sat_nosat_ch1", adc_val(1), 2000);
        check_val("sat_ovr", int'(adc_ovr_o), 1);
        pulse_clr();
        check_val("set_beats_clr", int'(adc_ovr_o), 1);

        // negative saturation from offset
        stage_cal(-10, 16384, 0, 16384);
        set_adc(-8192, 0);
        pulse_load();
        step(4);
        check_val("sat_lo_ch0", adc_val(0), -8192);
        check_val("off_ch1", adc_val(1), -10);
        check_val("sat_lo_ovr", int'(adc_ovr_o[0]), 1);

        // DAC coding at unity
        stage_cal(0, 16384, 0, 16384);
        pulse_load();
        set_dac(8191, -8192);
        step(4);
        check_val("dac_lat_n4", dac_raw(0), 'h1FFF);
        step(1);
        check_val("dac_pmax", dac_raw(0), 'h0000);
        check_val("dac_nmin", dac_raw(1), 'h3FFF);
        set_dac(0, 100);
        step(5);
        check_val("dac_zero", dac_raw(0), 'h1FFF);
        check_val("dac_100", dac_raw(1), 'h1F9B);
        check_val("dac_nosat", int'(dac_sat_o), 0);

        // DAC saturation
        stage_cal(0, 16384, 0, 32767);
        set_dac(8191, 100);
        pulse_load();
        step(5);
        check_val("dac_sat_raw0", dac_raw(0), 'h0000);
        check_val("dac_gain_raw1", dac_raw(1), 'h1F37);
        check_val("dac_sat_flag", int'(dac_sat_o), 1);

        // ramp
        stage_cal(0, 16384, 0, 16384);
        set_dac(5, 5);
        pulse_load();
        step(5);
        check_val("pre_ramp", dac_raw(0), 'h1FFA);
        dac_mode_i = 2'd1;
        step(5);
        check_val("ramp_0", dac_raw(0), 'h1FFF);
        step(1);
        check_val("ramp_1", dac_raw(0), 'h1FFE);
        check_val("ramp_1_ch1", dac_raw(1), 'h1FFE);
        step(1);
        check_val("ramp_2", dac_raw(0), 'h1FFD);
        step(8188);
        check_val("ramp_8190", dac_raw(0), 'h0001);
        step(1);
        check_val("ramp_8191", dac_raw(0), 'h0000);
        step(1);
        check_val("ramp_wrap", dac_raw(0), 'h3FFF);
        check_val("ramp_wrap_ch1", dac_raw(1), 'h3FFF);

        // mute ignores offset and gain
        stage_cal(0, 16384, 100, 16384);
        dac_mode_i = 2'd2;
        pulse_load();
        step(4);
        check_val("mute_ch0", dac_raw(0), 'h1FFF);
        check_val("mute_ch1", dac_raw(1), 'h1FFF);
        step(3);
        check_val("mute_hold", dac_raw(0), 'h1FFF);

        // loopback, 9-cycle ADC-to-DAC path
        stage_cal(0, 16384, 0, 16384);
        set_adc(500, 500);
        pulse_load();
        step(6);
        dac_mode_i = 2'd3;
        set_adc(1234, -4321);
        step(8);
        check_val("loop_n8", dac_raw(0), 'h1E0B);
        step(1);
        check_val("loop_n9_ch0", dac_raw(0), 'h1B2D);
        check_val("loop_n9_ch1", dac_raw(1), 'h30E0);

        // asynchronous reset mid-stream
        set_adc(2000, 2000);
        step(2);
        #3;
        adc_rst_i = 1'b0;
        #1;
        check_val("arst_adc0", adc_val(0), 0);
        check_val("arst_adc1", adc_val(1), 0);
        check_val("arst_valid", int'(adc_valid_o), 0);
        check_val("arst_ovr", int'(adc_ovr_o), 0);
        check_val("arst_dsat", int'(dac_sat_o), 0);
        check_val("arst_draw0", dac_raw(0), 'h1FFF);
        check_val("arst_draw1", dac_raw(1), 'h1FFF);
        step(2);
        adc_rst_i = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
